user_conv3x3: RTL and testbench



---
 rtl/user_conv3x3_pkg.sv | 124 ++++++++++++
 rtl/user_conv3x3_mac.sv | 66 ++++++
 rtl/user_conv3x3.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_user_conv3x3.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_conv3x3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : user_conv3x3_pkg
//  Description : Shared types and constants for the 3x3 convolution
//                accelerator: OBI bus structs, register byte offsets, kernel
//                selection enum, FSM state enum, fixed Sobel/Prewitt kernels
//                and a byte-enable merge helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package user_conv3x3_pkg;

    // ------------------------------------------------------------------------
    // OBI bus configuration and default request/response structs
    // ------------------------------------------------------------------------
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam int unsigned C_OBI_AW = 32;
    localparam int unsigned C_OBI_DW = 32;
    localparam int unsigned C_OBI_IW = 4;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: C_OBI_AW,
        DataWidth: C_OBI_DW,
        IdWidth:   C_OBI_IW
    };

    typedef struct packed {
        logic [C_OBI_AW-1:0]   addr;
        logic                  we;
        logic [C_OBI_DW/8-1:0] be;
        logic [C_OBI_DW-1:0]   wdata;
        logic [C_OBI_IW-1:0]   aid;
    } conv_obi_a_t;

    typedef struct packed {
        logic        req;
        conv_obi_a_t a;
    } conv_obi_req_t;

    typedef struct packed {
        logic [C_OBI_DW-1:0] rdata;
        logic [C_OBI_IW-1:0] rid;
        logic                err;
    } conv_obi_r_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        conv_obi_r_t r;
    } conv_obi_rsp_t;

    // ------------------------------------------------------------------------
    // Register map (byte offsets within the 256-byte window)
    // ------------------------------------------------------------------------
    localparam logic [7:0] C_OFF_PIX0      = 8'h00;
    localparam logic [7:0] C_OFF_PIX_LAST  = 8'h20;
    localparam logic [7:0] C_OFF_COEF0     = 8'h24;
    localparam logic [7:0] C_OFF_COEF_LAST = 8'h44;
    localparam logic [7:0] C_OFF_MODE      = 8'h48;
    localparam logic [7:0] C_OFF_CTRL      = 8'h4C;
    localparam logic [7:0] C_OFF_STATUS    = 8'h50;
    localparam logic [7:0] C_OFF_RESULT    = 8'h54;
    localparam logic [7:0] C_OFF_THRESH    = 8'h58;

    localparam int unsigned C_NUM_TAPS = 9;

    typedef enum logic [1:0] {
        MODE_SOBEL   = 2'd0,
        MODE_PREWITT = 2'd1,
        MODE_CUSTOM  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Fixed kernels, row-major. Three signed bits hold +/-2.
    // ------------------------------------------------------------------------
    localparam int unsigned C_KERN_W = 3;
    typedef logic signed [C_KERN_W-1:0] kcoef_t;

    localparam kcoef_t C_SOBEL_KX [C_NUM_TAPS] = '{
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd2, 3'sd0, 3'sd2,
        -3'sd1, 3'sd0, 3'sd1
    };
    localparam kcoef_t C_SOBEL_KY [C_NUM_TAPS] = '{
        -3'sd1, -3'sd2, -3'sd1,
         3'sd0,  3'sd0,  3'sd0,
         3'sd1,  3'sd2,  3'sd1
    };
    localparam kcoef_t C_PREWITT_KX [C_NUM_TAPS] = '{
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd1, 3'sd0, 3'sd1
    };
    localparam kcoef_t C_PREWITT_KY [C_NUM_TAPS] = '{
        -3'sd1, -3'sd1, -3'sd1,
         3'sd0,  3'sd0,  3'sd0,
         3'sd1,  3'sd1,  3'sd1
    };

    // Byte-lane merge of a write into the current read view of a register.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_conv3x3_mac.sv
`default_nettype none
// ============================================================================
//  Module      : user_conv3x3_mac
//  Description : Dual signed multiply-accumulate for the horizontal (gx) and
//                vertical (gy) gradients, one tap per enabled cycle.
//  Ports       : clk_i, rst_ni       clock / async active-low reset
//                clear_i             synchronous clear of both accumulators
//                en_i                accumulate current tap
//                pixel_i             unsigned pixel (zero-extended)
//                kx_i, ky_i          signed coefficients (sign-extended)
//                gx_o, gy_o          signed accumulators
//  Revision    : 1.0 - initial release
// ============================================================================
module user_conv3x3_mac #(
    parameter int unsigned PixelWidth = 8,
    parameter int unsigned CoefWidth  = 4,
    parameter int unsigned AccWidth   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        en_i,
    input  logic [PixelWidth-1:0]       pixel_i,
    input  logic signed [CoefWidth-1:0] kx_i,
    input  logic signed [CoefWidth-1:0] ky_i,
    output logic signed [AccWidth-1:0]  gx_o,
    output logic signed [AccWidth-1:0]  gy_o
);

    logic signed [AccWidth-1:0] w_pix_ext;
    logic signed [AccWidth-1:0] w_kx_ext;
    logic signed [AccWidth-1:0] w_ky_ext;
    logic signed [AccWidth-1:0] gx_q, gx_d;
    logic signed [AccWidth-1:0] gy_q, gy_d;

    assign w_pix_ext = $signed(AccWidth'(pixel_i));
    assign w_kx_ext  = AccWidth'(kx_i);
    assign w_ky_ext  = AccWidth'(ky_i);

    always_comb begin
        gx_d = gx_q;
        gy_d = gy_q;
        if (clear_i) begin
            gx_d = '0;
            gy_d = '0;
        end else if (en_i) begin
            gx_d = gx_q + w_pix_ext * w_kx_ext;
            gy_d = gy_q + w_pix_ext * w_ky_ext;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gx_q <= '0;
            gy_q <= '0;
        end else begin
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    assign gx_o = gx_q;
    assign gy_o = gy_q;

endmodule
`default_nettype wire

// File: rtl/user_conv3x3.sv
`default_nettype none
// ============================================================================
//  Module      : user_conv3x3
//  Description : OBI-slave 3x3 convolution accelerator. Holds the register
//                file, OBI decode and the IDLE/ACCUM/FINAL sequencer; the
//                arithmetic lives in user_conv3x3_mac.
//  Ports       : clk_i      clock
//                rst_ni     asynchronous active-low reset
//                obi_req_i  OBI request (always granted)
//                obi_rsp_o  OBI response, one cycle after handshake
//                irq_o      level interrupt = done & irq_en
//  Revision    : 1.0 - initial release
// ============================================================================
module user_conv3x3
    import user_conv3x3_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg     = ObiDefaultConfig,
    parameter type         obi_req_t  = conv_obi_req_t,
    parameter type         obi_rsp_t  = conv_obi_rsp_t,
    parameter int unsigned PixelWidth = 8,
    parameter int unsigned CoeffWidth = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    localparam int unsigned AccWidth = PixelWidth + CoeffWidth + 4;
    // The MAC coefficient port must hold both custom and fixed (+/-2) taps.
    localparam int unsigned MacCoefW = (CoeffWidth > C_KERN_W) ? CoeffWidth : C_KERN_W;

    // ------------------------------------------------------------------------
    // Captured request (address phase) presented in the response cycle
    // ------------------------------------------------------------------------
    logic                         rvalid_q;
    logic                         we_q;
    logic [7:0]                   addr_q;
    logic [3:0]                   be_q;
    logic [31:0]                  wdata_q;
    logic [ObiCfg.IdWidth-1:0]    rid_q;
    logic                         w_unused_addr_hi;

    assign w_unused_addr_hi = ^obi_req_i.a.addr[31:8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                we_q    <= obi_req_i.a.we;
                addr_q  <= obi_req_i.a.addr[7:0];
                be_q    <= obi_req_i.a.be;
                wdata_q <= obi_req_i.a.wdata;
                rid_q   <= obi_req_i.a.aid;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------------
    logic [PixelWidth-1:0] pix_q  [C_NUM_TAPS];
    logic [CoeffWidth-1:0] coef_q [C_NUM_TAPS];
    mode_e                 mode_q;
    logic                  irq_en_q;
    logic [31:0]           thresh_q;
    logic [AccWidth:0]     result_q;
    logic                  done_q;
    logic                  edge_q;

    state_e                state_q, state_d;
    logic [3:0]            tap_q, tap_d;
    logic                  w_busy;

    assign w_busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------------
    // Address decode and read view of the addressed register
    // ------------------------------------------------------------------------
    logic        w_hit_pix;
    logic        w_hit_coef;
    logic [3:0]  w_pix_idx;
    logic [3:0]  w_coef_idx;
    logic        w_mapped;
    logic [31:0] w_rd_view;
    logic [31:0] w_wr_val;

    assign w_hit_pix  = (addr_q <= C_OFF_PIX_LAST);
    assign w_hit_coef = (addr_q >= C_OFF_COEF0) && (addr_q <= C_OFF_COEF_LAST);
    assign w_pix_idx  = 4'(addr_q[7:2]);
    assign w_coef_idx = 4'(addr_q[7:2] - C_OFF_COEF0[7:2]);

    always_comb begin
        w_rd_view = '0;
        w_mapped  = 1'b1;
        if (addr_q[1:0] != 2'b00) begin
            w_mapped = 1'b0;
        end else if (w_hit_pix) begin
            w_rd_view = 32'(pix_q[w_pix_idx]);
        end else if (w_hit_coef) begin
            w_rd_view = 32'(coef_q[w_coef_idx]);
        end else begin
            case (addr_q)
                C_OFF_MODE:   w_rd_view = 32'(mode_q);
                C_OFF_CTRL:   w_rd_view = {30'b0, irq_en_q, 1'b0};
                C_OFF_STATUS: w_rd_view = {29'b0, edge_q, done_q, w_busy};
                C_OFF_RESULT: w_rd_view = 32'(result_q);
                C_OFF_THRESH: w_rd_view = thresh_q;
                default:      w_mapped  = 1'b0;
            endcase
        end
    end

    assign w_wr_val = be_merge(w_rd_view, wdata_q, be_q);

    // ------------------------------------------------------------------------
    // Access legality and write strobes (all qualified by the response cycle)
    // ------------------------------------------------------------------------
    logic w_err;
    logic w_wr_pix, w_wr_coef, w_wr_mode, w_wr_ctrl, w_wr_thresh;
    logic w_start, w_clr_done, w_start_bit;

    assign w_start_bit = be_q[0] & wdata_q[0];

    always_comb begin
        w_err       = 1'b0;
        w_wr_pix    = 1'b0;
        w_wr_coef   = 1'b0;
        w_wr_mode   = 1'b0;
        w_wr_ctrl   = 1'b0;
        w_wr_thresh = 1'b0;
        w_start     = 1'b0;
        w_clr_done  = 1'b0;
        if (rvalid_q) begin
            if (!w_mapped) begin
                w_err = 1'b1;
            end else if (we_q) begin
                if (w_hit_pix) begin
                    w_err    = w_busy;
                    w_wr_pix = !w_busy;
                end else if (w_hit_coef) begin
                    w_err     = w_busy;
                    w_wr_coef = !w_busy;
                end else begin
                    case (addr_q)
                        C_OFF_MODE: begin
                            if (w_busy || (w_wr_val[1:0] == MODE_RSVD)) begin
                                w_err = 1'b1;
                            end else begin
                                w_wr_mode = 1'b1;
                            end
                        end
                        C_OFF_CTRL: begin
                            // A start while busy rejects the whole write.
                            if (w_busy && w_start_bit) begin
                                w_err = 1'b1;
                            end else begin
                                w_wr_ctrl = 1'b1;
                                w_start   = w_start_bit;
                            end
                        end
                        C_OFF_STATUS: w_clr_done  = be_q[0] & wdata_q[1];
                        C_OFF_THRESH: w_wr_thresh = 1'b1;
                        default:      w_err       = 1'b1;
                    endcase
                end
            end
        end
    end

    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = obi_req_i.req;
        obi_rsp_o.rvalid   = rvalid_q;
        obi_rsp_o.r.rid    = rid_q;
        obi_rsp_o.r.err    = w_err;
        obi_rsp_o.r.rdata  = (rvalid_q && !we_q && !w_err) ? w_rd_view : '0;
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    logic w_mac_clear, w_mac_en, w_final;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        w_mac_clear = 1'b0;
        w_mac_en    = 1'b0;
        w_final     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d     = S_ACCUM;
                    tap_d       = '0;
                    w_mac_clear = 1'b1;
                end
            end
            S_ACCUM: begin
                w_mac_en = 1'b1;
                if (tap_q == 4'(C_NUM_TAPS - 1)) begin
                    state_d = S_FINAL;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_FINAL: begin
                w_final = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
        end
    end

    // ------------------------------------------------------------------------
    // Kernel coefficient selection for the current tap
    // ------------------------------------------------------------------------
    logic signed [MacCoefW-1:0] w_kx, w_ky;

    always_comb begin
        w_kx = '0;
        w_ky = '0;
        case (mode_q)
            MODE_SOBEL: begin
                w_kx = MacCoefW'(C_SOBEL_KX[tap_q]);
                w_ky = MacCoefW'(C_SOBEL_KY[tap_q]);
            end
            MODE_PREWITT: begin
                w_kx = MacCoefW'(C_PREWITT_KX[tap_q]);
                w_ky = MacCoefW'(C_PREWITT_KY[tap_q]);
            end
            MODE_CUSTOM: begin
                w_kx = MacCoefW'($signed(coef_q[tap_q]));
            end
            default: ;
        endcase
    end

    logic signed [AccWidth-1:0] w_gx, w_gy;

    user_conv3x3_mac #(
        .PixelWidth (PixelWidth),
        .CoefWidth  (MacCoefW),
        .AccWidth   (AccWidth)
    ) u_mac (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (w_mac_clear),
        .en_i    (w_mac_en),
        .pixel_i (pix_q[tap_q]),
        .kx_i    (w_kx),
        .ky_i    (w_ky),
        .gx_o    (w_gx),
        .gy_o    (w_gy)
    );

    // Magnitude: the accumulator range never reaches its most-negative code,
    // so a plain negate is a safe absolute value.
    logic [AccWidth-1:0] w_abs_x, w_abs_y;
    logic [AccWidth:0]   w_mag;
    logic                w_edge;

    assign w_abs_x = w_gx[AccWidth-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    assign w_abs_y = w_gy[AccWidth-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    assign w_mag   = {1'b0, w_abs_x} + {1'b0, w_abs_y};
    assign w_edge  = (32'(w_mag) >= thresh_q);

    // ------------------------------------------------------------------------
    // Register file updates
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < C_NUM_TAPS; i++) begin
                pix_q[i]  <= '0;
                coef_q[i] <= '0;
            end
            mode_q   <= MODE_SOBEL;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            if (w_wr_pix) begin
                pix_q[w_pix_idx] <= w_wr_val[PixelWidth-1:0];
            end
            if (w_wr_coef) begin
                coef_q[w_coef_idx] <= w_wr_val[CoeffWidth-1:0];
            end
            if (w_wr_mode) begin
                mode_q <= mode_e'(w_wr_val[1:0]);
            end
            if (w_wr_ctrl) begin
                irq_en_q <= w_wr_val[1];
            end
            if (w_wr_thresh) begin
                thresh_q <= w_wr_val;
            end
            // FINAL has priority so a concurrent W1C cannot lose a completion.
            if (w_final) begin
                result_q <= w_mag;
                edge_q   <= w_edge;
                done_q   <= 1'b1;
            end else if (w_start) begin
                edge_q   <= 1'b0;
                done_q   <= 1'b0;
            end else if (w_clr_done) begin
                done_q   <= 1'b0;
            end
        end
    end

    assign irq_o = done_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_user_conv3x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_conv3x3
//  Description : Self-checking bench for user_conv3x3: directed kernel cases,
//                interrupt timing, busy/error handling, mid-run reset and a
//                randomized sweep against a behavioural gradient model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_user_conv3x3;
    import user_conv3x3_pkg::*;

    localparam logic [7:0] A_COEF0  = 8'h24;
    localparam logic [7:0] A_MODE   = 8'h48;
    localparam logic [7:0] A_CTRL   = 8'h4C;
    localparam logic [7:0] A_STATUS = 8'h50;
    localparam logic [7:0] A_RESULT = 8'h54;
    localparam logic [7:0] A_THRESH = 8'h58;

    logic          clk = 1'b0;
    logic          rst_n;
    conv_obi_req_t req;
    conv_obi_rsp_t rsp;
    logic          irq;

    user_conv3x3 dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One OBI transaction: request driven for one cycle, response sampled in
    // the following cycle. Returns at the negedge inside the response cycle.
    task automatic bus(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        logic [3:0] aid;
        aid = 4'($urandom_range(0, 15));
        @(negedge clk);
        req.req     = 1'b1;
        req.a.addr  = {24'h0, addr};
        req.a.we    = we;
        req.a.be    = 4'hF;
        req.a.wdata = wdata;
        req.a.aid   = aid;
        #1;
        check_val("gnt", 32'(rsp.gnt), 32'd1);
        @(negedge clk);
        check_val("rvalid", 32'(rsp.rvalid), 32'd1);
        check_val("rid", 32'(rsp.r.rid), 32'(aid));
        rdata = rsp.r.rdata;
        err   = rsp.r.err;
        req   = '0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        e;
        bus(1'b1, addr, data, rd, e);
        check_val("wr_err", 32'(e), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        bus(1'b0, addr, 32'h0, rd, e);
        check_val("rd_err", 32'(e), 32'd0);
        check_val(tag, rd, exp);
    endtask

    task automatic expect_err(input string tag, input bit we, input logic [7:0] addr,
                              input logic [31:0] data);
        logic [31:0] rd;
        logic        e;
        bus(we, addr, data, rd, e);
        check_val(tag, 32'(e), 32'd1);
        check_val({tag, "_rdata"}, rd, 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: kernels from their closed form
    //   Kx[r][c] = (c-1) * w(r), Ky[r][c] = (r-1) * w(c),
    //   w = centre weight on the middle row/column (2 Sobel, 1 Prewitt).
    // ------------------------------------------------------------------------
    int m_pix  [9];
    int m_coef [9];
    int m_mode;
    bit m_irq_en;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_result();
        int gx, gy, ctr, p, wr_, wc_;
        gx  = 0;
        gy  = 0;
        ctr = (m_mode == 0) ? 2 : 1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p = m_pix[r*3 + c];
                if (m_mode == 2) begin
                    gx += m_coef[r*3 + c] * p;
                end else begin
                    wr_ = (r == 1) ? ctr : 1;
                    wc_ = (c == 1) ? ctr : 1;
                    gx += (c - 1) * wr_ * p;
                    gy += (r - 1) * wc_ * p;
                end
            end
        end
        return iabs(gx) + iabs(gy);
    endfunction

    task automatic load_regs();
        for (int i = 0; i < 9; i++) wr(8'(i*4), 32'(m_pix[i]));
        for (int i = 0; i < 9; i++) wr(8'(A_COEF0 + 8'(i*4)), 32'(m_coef[i]) & 32'hF);
        wr(A_MODE, 32'(m_mode));
    endtask

    task automatic sobel_pattern();
        for (int i = 0; i < 9; i++) m_pix[i] = ((i % 3) == 2) ? 255 : 0;
    endtask

    // Start, let the run finish, then check STATUS and RESULT.
    task automatic run_check(input string tag, input int exp_res, input bit exp_edge);
        wr(A_CTRL, {30'b0, m_irq_en, 1'b1});
        repeat (10) @(negedge clk);
        rd_chk({tag, "_status"}, A_STATUS, {29'b0, exp_edge, 1'b1, 1'b0});
        rd_chk({tag, "_result"}, A_RESULT, 32'(exp_res));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int res, thr;
        logic [31:0] rd;
        logic        e;

        req      = '0;
        rst_n    = 1'b0;
        m_irq_en = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_rvalid", 32'(rsp.rvalid), 32'd0);
        check_val("reset_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        rd_chk("reset_status", A_STATUS, 32'd0);
        rd_chk("reset_mode", A_MODE, 32'd0);
        rd_chk("reset_result", A_RESULT, 32'd0);
        rd_chk("reset_thresh", A_THRESH, 32'd0);
        rd_chk("reset_ctrl", A_CTRL, 32'd0);

        // Sobel vertical edge
        sobel_pattern();
        for (int i = 0; i < 9; i++) m_coef[i] = 0;
        m_mode = 0;
        load_regs();
        rd_chk("pix2_readback", 8'h08, 32'd255);
        run_check("sobel", 1020, 1'b1);

        // Prewitt, threshold below and at the result
        m_mode = 1;
        wr(A_MODE, 32'd1);
        wr(A_THRESH, 32'd800);
        run_check("prewitt_thr800", 765, 1'b0);
        wr(A_THRESH, 32'd765);
        run_check("prewitt_thr765", 765, 1'b1);

        // Custom kernels
        m_mode = 2;
        for (int i = 0; i < 9; i++) begin m_pix[i] = i + 1; m_coef[i] = 1; end
        load_regs();
        run_check("custom_ones", 45, 1'b0);
        for (int i = 0; i < 9; i++) begin m_pix[i] = 10; m_coef[i] = -1; end
        load_regs();
        run_check("custom_neg", 90, 1'b0);

        // Interrupt latency and W1C of done
        sobel_pattern();
        m_mode = 0;
        load_regs();
        m_irq_en = 1'b1;
        wr(A_CTRL, 32'd3);                      // start committed in cycle T
        repeat (8) @(negedge clk);              // T+8
        rd_chk("busy_at_t10", A_STATUS, 32'h1); // response in T+10
        check_val("irq_t10", 32'(irq), 32'd0);
        @(negedge clk);                         // T+11
        check_val("irq_t11", 32'(irq), 32'd1);
        rd_chk("status_done", A_STATUS, 32'h6);
        rd_chk("result_irq_run", A_RESULT, 32'd1020);
        wr(A_STATUS, 32'h2);
        check_val("irq_before_w1c", 32'(irq), 32'd1);
        @(negedge clk);
        check_val("irq_after_w1c", 32'(irq), 32'd0);
        rd_chk("status_after_w1c", A_STATUS, 32'h4);

        // Busy rejections and bad accesses
        m_irq_en = 1'b0;
        wr(A_CTRL, 32'd1);                      // T
        repeat (2) @(negedge clk);
        expect_err("start_busy", 1'b1, A_CTRL, 32'd1);     // response T+4
        expect_err("pix_busy", 1'b1, 8'h00, 32'd77);       // response T+6
        expect_err("mode_busy", 1'b1, A_MODE, 32'd1);      // response T+8
        repeat (2) @(negedge clk);
        rd_chk("no_restart_status", A_STATUS, 32'h6);      // response T+12
        rd_chk("result_kept", A_RESULT, 32'd1020);
        rd_chk("pix0_kept", 8'h00, 32'd0);
        rd_chk("mode_kept", A_MODE, 32'd0);
        expect_err("unmapped_0x60", 1'b0, 8'h60, 32'd0);
        expect_err("mode_rsvd", 1'b1, A_MODE, 32'd3);
        rd_chk("mode_after_rsvd", A_MODE, 32'd0);
        expect_err("result_ro", 1'b1, A_RESULT, 32'd5);
        expect_err("misaligned", 1'b0, 8'h01, 32'd0);

        // Reset in the middle of accumulation (k = 4)
        wr(A_MODE, 32'd1);
        wr(A_CTRL, 32'd3);                      // T
        repeat (5) @(negedge clk);              // T+5
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_irq", 32'(irq), 32'd0);
        check_val("rst_mid_rvalid", 32'(rsp.rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rst_mid_status", A_STATUS, 32'd0);
        rd_chk("rst_mid_result", A_RESULT, 32'd0);
        rd_chk("rst_mid_mode", A_MODE, 32'd0);
        rd_chk("rst_mid_ctrl", A_CTRL, 32'd0);
        sobel_pattern();
        m_mode = 0;
        load_regs();
        run_check("after_reset", 1020, 1'b1);

        // Randomized sweep
        for (int it = 0; it < 16; it++) begin
            m_mode = $urandom_range(0, 2);
            for (int i = 0; i < 9; i++) begin
                m_pix[i]  = $urandom_range(0, 255);
                m_coef[i] = int'($urandom_range(0, 15)) - 8;
            end
            res = model_result();
            case (it % 3)
                0:       thr = res;
                1:       thr = res + 1;
                default: thr = $urandom_range(0, 2000);
            endcase
            load_regs();
            wr(A_THRESH, 32'(thr));
            run_check($sformatf("rand%0d", it), res, res >= thr);
        end

        bus(1'b0, A_THRESH, 32'h0, rd, e);
        check_val("thresh_readback", rd, 32'(thr));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
